regfile_param: RTL and testbench

Parametrised integer register file for the single-cycle RISC-V core, replacing the fixed 2-read/1-write `registerfile`. It adds configurable data width and depth, hardwired-zero register 0, and a sequenced clear engine that zeroes every register after reset or on request. It also offers optional same-cycle write-to-read bypass. It sits between decode, which drives the read addresses, and writeback, which drives the write port.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clear_fsm.sv | 52 +++++
 rtl/regfile_param.sv | 92 +++++++++
 tb/tb_regfile_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state type for the parametrised register file.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  localparam logic RF_CLEAR = 1'b0;
  localparam logic RF_READY = 1'b1;

  // Register 0 reads as zero and has no storage behind it.
  localparam int unsigned RF_ZERO = 0;

  typedef enum logic {
    StClear = RF_CLEAR,
    StReady = RF_READY
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every stored register (1..DEPTH-1) writing zero, then reports Ready.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] IdxFirst = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IdxLast  = '1;

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StClear;
      clr_idx_q <= IdxFirst;
    end else begin
      case (state_q)
        StClear: begin
          // A clear request arriving mid-sequence is ignored.
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == IdxLast) begin
            state_q <= StReady;
          end
        end
        StReady: begin
          if (clear) begin
            state_q   <= StClear;
            clr_idx_q <= IdxFirst;
          end
        end
        default: begin
          state_q   <= StClear;
          clr_idx_q <= IdxFirst;
        end
      endcase
    end
  end

  assign ready    = (state_q == StReady);
  assign clr_we   = (state_q == StClear) && !reset;
  assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write integer register file with hardwired x0 and a clear engine.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Clear,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              Ready
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(RF_ZERO);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              user_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  logic [DATA_W-1:0] mem_q [1:DEPTH-1];

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock    (clock),
    .reset    (reset),
    .clear    (Clear),
    .ready    (Ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Clear and reset both take priority over a normal write.
  assign user_we = Ready && !Clear && !reset && RegWrite && (WriteReg != ZeroAddr);

  always_comb begin
    wr_en   = user_we;
    wr_addr = WriteReg;
    wr_data = WriteData;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  // Address 0 matches no entry, so it falls through to zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (Read1 == ADDR_W'(i)) rd1 = mem_q[i];
      if (Read2 == ADDR_W'(i)) rd2 = mem_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = Ready && RegWrite && !Clear && (WriteReg != ZeroAddr);

  assign Data1 = !Ready                         ? '0        :
                 (byp_en && (WriteReg == Read1)) ? WriteData : rd1;
  assign Data2 = !Ready                         ? '0        :
                 (byp_en && (WriteReg == Read2)) ? WriteData : rd2;
`else
  assign Data1 = Ready ? rd1 : '0;
  assign Data2 = Ready ? rd2 : '0;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a high-level model predicts outputs, a monitor compares.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct {
    string         tag;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          rdy;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          Clear = 1'b0;
  logic [AW-1:0] Read1 = '0;
  logic [AW-1:0] Read2 = '0;
  logic [AW-1:0] WriteReg = '0;
  logic [DW-1:0] WriteData = '0;
  logic          RegWrite = 1'b0;
  logic [DW-1:0] Data1;
  logic [DW-1:0] Data2;
  logic          Ready;

  always #5 clock = ~clock;

  regfile_param #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .Clear     (Clear),
    .Read1     (Read1),
    .Read2     (Read2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .Data1     (Data1),
    .Data2     (Data2),
    .Ready     (Ready)
  );

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   known    = 1'b0;

  // Model: contents as a plain array, plus a count of clear edges still to go.
  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m = 1'b1;
  int            left_m = 0;

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    if (busy_m || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !Clear && WriteReg != 0 && WriteReg == a) return WriteData;
`endif
    return mem_m[a];
  endfunction

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".Ready"}, {31'd0, Ready}, {31'd0, e.rdy});
      chk({e.tag, ".Data1"}, Data1, e.d1);
      chk({e.tag, ".Data2"}, Data2, e.d2);
    end
  end

  task automatic cyc(string tag, bit r, bit c, logic [AW-1:0] r1, logic [AW-1:0] r2,
                     bit we, logic [AW-1:0] wa, logic [DW-1:0] wd);
    reset     = r;
    Clear     = c;
    Read1     = r1;
    Read2     = r2;
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    if (known) sb.push_back('{tag, model_read(r1), model_read(r2), !busy_m});
    @(posedge clock);
    if (r) begin
      busy_m = 1'b1;
      left_m = DEPTH - 1;
      known  = 1'b1;
    end else if (busy_m) begin
      left_m--;
      if (left_m == 0) begin
        busy_m = 1'b0;
        foreach (mem_m[i]) mem_m[i] = '0;
      end
    end else if (c) begin
      busy_m = 1'b1;
      left_m = DEPTH - 1;
    end else if (we && wa != 0) begin
      mem_m[wa] = wd;
    end
    #1;
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b0, 1'b0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
          1'b0, '0, '0);
    end
  endtask

  initial begin
    // Power-up clear sequence
    cyc("rst", 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle("clr0", 33);

    cyc("wr3", 1'b0, 1'b0, 3, 5, 1'b1, 3, 32'hABCDEFFF);
    cyc("wr5", 1'b0, 1'b0, 3, 5, 1'b1, 5, 32'hFBCDE111);
    cyc("rd35", 1'b0, 1'b0, 3, 5, 1'b0, 5, 32'h0);
    cyc("rd7_10", 1'b0, 1'b0, 7, 10, 1'b0, 0, 32'h0);
    cyc("wr0", 1'b0, 1'b0, 0, 3, 1'b1, 0, 32'hDEADBEEF);
    cyc("rd0", 1'b0, 1'b0, 0, 0, 1'b0, 0, 32'h0);

    // Clear wins over a same-cycle write
    cyc("clrwr4", 1'b0, 1'b1, 4, 3, 1'b1, 4, 32'h12345678);
    idle("clr1", 4);
    cyc("clr_in_clr", 1'b0, 1'b1, 4, 3, 1'b1, 4, 32'h55AA55AA);
    idle("clr1b", 28);
    cyc("rd4_3", 1'b0, 1'b0, 4, 3, 1'b0, 0, 32'h0);

    // Reset during a clear restarts the sequence
    cyc("rst2", 1'b1, 1'b0, 1, 2, 1'b0, 0, 32'h0);
    idle("clr2", 9);
    cyc("rst3", 1'b1, 1'b1, 1, 2, 1'b1, 2, 32'h77);
    idle("clr3", 33);

    // Same-cycle write/read of one register
    cyc("wr6", 1'b0, 1'b0, 6, 6, 1'b1, 6, 32'h00001111);
    cyc("byp6", 1'b0, 1'b0, 6, 6, 1'b1, 6, 32'h0000CAFE);
    cyc("rd6", 1'b0, 1'b0, 6, 6, 1'b0, 0, 32'h0);
    cyc("byp_clr", 1'b0, 1'b1, 6, 6, 1'b1, 6, 32'h0000BEEF);
    idle("clr4", 32);

    for (int i = 0; i < 600; i++) begin
      cyc("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
          AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
          bit'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
    end
    cyc("tail", 1'b0, 1'b0, 1, 2, 1'b0, 0, 32'h0);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
